// File: rtl/gpio_write_arbiter.sv
// Round-robin arbiter that merges masked writes from several requesters into a
// shadow copy of the GPIO output register and issues one STR per grant.
module gpio_write_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] GPIO_ADDR = 32'd32,
    parameter logic [4:0]  STR_UOP   = 5'd2,
    parameter logic [4:0]  NOP_UOP   = 5'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  wr_data,
    input  logic [32*NUM_REQ-1:0]  wr_mask,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic [4:0]             uop,
    output logic [31:0]            addr,
    output logic [31:0]            state_in,
    output logic [31:0]            shadow
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {INIT, IDLE, ISSUE, ACK} state_t;

    state_t            state, state_nx;
    logic              init_done;
    logic [IW-1:0]     rr_ptr, idx, sel_idx;
    logic              sel_found;
    logic [31:0]       sel_data, sel_mask, merged;
    logic [NUM_REQ-1:0] gnt_nx;
    logic              busy_nx;
    logic [4:0]        uop_nx;
    logic [31:0]       addr_nx, state_in_nx;

    // Handshake: req[i] is held until gnt[i]; gnt is a one-cycle pulse after the
    // write has been issued, and data/mask are sampled only in the IDLE cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign sel_data = wr_data[32*int'(sel_idx) +: 32];
    assign sel_mask = wr_mask[32*int'(sel_idx) +: 32];
    assign merged   = (shadow & ~sel_mask) | (sel_data & sel_mask);

    // INIT spends one edge driving the zeroing STR and a second edge leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_done <= 1'b0;
            rr_ptr    <= '0;
            idx       <= '0;
            shadow    <= '0;
            gnt       <= '0;
            busy      <= 1'b1;
            uop       <= NOP_UOP;
            addr      <= '0;
            state_in  <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            busy     <= busy_nx;
            uop      <= uop_nx;
            addr     <= addr_nx;
            state_in <= state_in_nx;
            if (state == INIT) begin
                init_done <= 1'b1;
            end
            if (state == IDLE && sel_found) begin
                idx <= sel_idx;
            end
            if (state == ISSUE) begin
                shadow <= state_in;
                rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    state_nx = init_done ? IDLE : INIT;
            IDLE:    if (sel_found) state_nx = ISSUE;
            ISSUE:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        uop_nx      = NOP_UOP;
        addr_nx     = '0;
        state_in_nx = shadow;
        gnt_nx      = '0;
        busy_nx     = 1'b1;
        unique case (state_nx)
            INIT: begin
                uop_nx      = STR_UOP;
                addr_nx     = GPIO_ADDR;
                state_in_nx = '0;
            end
            IDLE: busy_nx = 1'b0;
            ISSUE: begin
                uop_nx      = STR_UOP;
                addr_nx     = GPIO_ADDR;
                state_in_nx = merged;
            end
            ACK: begin
                gnt_nx[idx] = 1'b1;
                state_in_nx = state_in;
            end
            default: busy_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Self-checking bench for gpio_write_arbiter: directed scenarios followed by
// random traffic, all checked against a cycle-table reference model.
module tb_gpio_write_arbiter;
    localparam int          NUM_REQ   = 2;
    localparam logic [31:0] GPIO_ADDR = 32'd32;
    localparam logic [4:0]  STR_UOP   = 5'd2;
    localparam logic [4:0]  NOP_UOP   = 5'd0;
    localparam int          MAXC      = 4096;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req = '0;
    logic [32*NUM_REQ-1:0] wr_data = '0;
    logic [32*NUM_REQ-1:0] wr_mask = '0;
    logic [NUM_REQ-1:0]    gnt;
    logic                  busy;
    logic [4:0]            uop;
    logic [31:0]           addr, state_in, shadow;

    gpio_write_arbiter #(
        .NUM_REQ(NUM_REQ), .GPIO_ADDR(GPIO_ADDR), .STR_UOP(STR_UOP), .NOP_UOP(NOP_UOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_data(wr_data), .wr_mask(wr_mask),
        .gnt(gnt), .busy(busy), .uop(uop), .addr(addr), .state_in(state_in), .shadow(shadow)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          str_at[MAXC];
    int          gnt_at[MAXC];
    logic [31:0] exp_q[$];
    logic [31:0] gpio_now, gpio_pend;
    int          rr, arb_ok;
    bit          init_pending;
    bit          inflight[NUM_REQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // At each active edge: decide what the arbiter must do from the spec's rules.
    task automatic model_edge();
        int w;
        logic [31:0] d, m;
        if (!rst_n) return;
        if (init_pending) begin
            str_at[cyc] = 1'b1;
            exp_q.push_back(32'h0);
            init_pending = 1'b0;
            arb_ok = cyc + 2;
        end else if (cyc >= arb_ok && req != '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && req[(rr + k) % NUM_REQ]) w = (rr + k) % NUM_REQ;
            d = wr_data[32*w +: 32];
            m = wr_mask[32*w +: 32];
            gpio_pend = (gpio_now & ~m) | (d & m);
            exp_q.push_back(gpio_pend);
            str_at[cyc] = 1'b1;
            gnt_at[cyc+1] = w + 1;
            rr = (w + 1) % NUM_REQ;
            arb_ok = cyc + 3;
            inflight[w] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] eg;
        bit s;
        if (!rst_n) begin
            check("rst_uop", 32'(uop), 32'(NOP_UOP));
            check("rst_addr", addr, 32'h0);
            check("rst_state_in", state_in, 32'h0);
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_busy", 32'(busy), 32'h1);
            check("rst_shadow", shadow, 32'h0);
            return;
        end
        if (gnt_at[cyc] != 0) gpio_now = gpio_pend;
        s  = str_at[cyc];
        eg = '0;
        if (gnt_at[cyc] != 0) eg[gnt_at[cyc]-1] = 1'b1;
        check("uop", 32'(uop), 32'(s ? STR_UOP : NOP_UOP));
        check("addr", addr, s ? GPIO_ADDR : 32'h0);
        if (s) begin
            if (exp_q.size() == 0) check("exp_q_underflow", 32'h1, 32'h0);
            else check("state_in_str", state_in, exp_q.pop_front());
        end else begin
            check("state_in_hold", state_in, gpio_now);
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("shadow", shadow, gpio_now);
        check("busy", 32'(busy), 32'(s || eg != '0));
        if (eg != '0) inflight[gnt_at[cyc]-1] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = cyc + 1; i <= cyc + 3; i++) begin
            str_at[i] = 1'b0;
            gnt_at[i] = 0;
        end
        exp_q.delete();
        gpio_now = '0;
        rr = 0;
        init_pending = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) inflight[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] m);
        req[i] = 1'b1;
        wr_data[32*i +: 32] = d;
        wr_mask[32*i +: 32] = m;
    endtask

    task automatic rand_data(input int i);
        logic [31:0] m;
        case ($urandom_range(3, 0))
            0:       m = 32'h0;
            1:       m = 32'hFFFF_FFFF;
            default: m = $urandom;
        endcase
        wr_data[32*i +: 32] = $urandom;
        wr_mask[32*i +: 32] = m;
    endtask

    task automatic wait_gnt(input int i, input string tag);
        int n = 0;
        do begin step(); n++; end while (!gnt[i] && n < 30);
        if (!gnt[i]) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_any_gnt(input string tag);
        int n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 30);
        if (gnt == '0) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int order[4] = '{0, 1, 0, 1};
        int last, g1, t0, n;
        rst_n = 1'b1;
        #2 apply_reset();
        repeat (2) step();

        // Reset release: one zeroing STR, then idle
        rst_n = 1'b1;
        step();
        check("t1_init_uop", 32'(uop), 32'(STR_UOP));
        check("t1_init_data", state_in, 32'h0);
        step();
        check("t1_idle_busy", 32'(busy), 32'h0);
        step();

        // Single masked writes from each requester
        set_req(0, 32'hFFFF_FFFF, 32'h0000_00FF);
        t0 = cyc;
        wait_gnt(0, "t2");
        check("t2_latency", 32'(cyc - t0), 32'd2);
        req[0] = 1'b0;
        check("t2_shadow", shadow, 32'h0000_00FF);
        set_req(1, 32'h0, 32'h0000_000F);
        wait_gnt(1, "t3");
        req[1] = 1'b0;
        check("t3_shadow", shadow, 32'h0000_00F0);

        // Both held: alternating grants, three cycles apart
        req = '1;
        rand_data(0);
        rand_data(1);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any_gnt("t4");
            check("t4_order", 32'(gnt), 32'(1 << order[k]));
            if (k > 0) check("t4_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) rand_data(i);
        end
        req = '0;

        // Reset during ISSUE of a requester-1 write
        set_req(1, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        n = 0;
        do begin step(); n++; end while (uop != STR_UOP && n < 10);
        check("t5_saw_issue", 32'(uop), 32'(STR_UOP));
        apply_reset();
        step();
        step();
        set_req(0, $urandom, $urandom);
        set_req(1, $urandom, $urandom);
        rst_n = 1'b1;
        step();
        check("t5_init_uop", 32'(uop), 32'(STR_UOP));
        check("t5_init_data", state_in, 32'h0);
        wait_any_gnt("t5_first");
        check("t5_first_gnt", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        wait_gnt(1, "t5_second");
        req[1] = 1'b0;

        // Requester 0 drops req right after being sampled
        set_req(0, 32'h1234_5678, 32'hFFFF_0000);
        n = 0;
        do begin step(); n++; end while (!inflight[0] && n < 10);
        req[0] = 1'b0;
        wait_gnt(0, "t6_first");
        g1 = cyc;
        set_req(0, 32'h0000_BEEF, 32'h0000_FFFF);
        wait_gnt(0, "t6_second");
        check("t6_gap", 32'(cyc - g1), 32'd3);
        req[0] = 1'b0;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else rand_data(i);
                end else if (inflight[i]) begin
                    if ($urandom_range(3, 0) == 0) req[i] = 1'b0;
                    if ($urandom_range(3, 0) == 0) rand_data(i);
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    rand_data(i);
                end
            end
        end
        req = '0;
        repeat (5) step();
        check("drain_exp_q", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
